// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the CPU control/datapath and the
// iterative multiply/divide unit.
interface mult_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on
// magnitudes plus a sign-fix cycle) producing Hi/Lo for the CPU datapath.
//
// state  | meaning
// IDLE   | waiting for start; done/div_zero pulse is issued from here
// MULT   | one Booth iteration per cycle, WIDTH cycles
// DIV    | one quotient bit per cycle, WIDTH cycles
// FIX    | apply quotient/remainder signs, write hi/lo
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mult_div_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FIX} state_t;

  state_t state_q, state_d;

  // MULT: {P (WIDTH+1, sign-extended), multiplier, q-1}
  // DIV : {unused bit, remainder (WIDTH+1), quotient/dividend}
  logic [2*WIDTH+1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH:0]     p_sum, rem_sh, trial;
  logic [2*WIDTH+1:0] booth_nxt, div_nxt;
  logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;

  // Single-iteration datapath for both algorithms plus operand magnitudes
  always_comb begin
    p_sum = acc_q[2*WIDTH+1:WIDTH+1];
    case (acc_q[1:0])
      2'b01:   p_sum = acc_q[2*WIDTH+1:WIDTH+1] + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   p_sum = acc_q[2*WIDTH+1:WIDTH+1] - {mcand_q[WIDTH-1], mcand_q};
      default: p_sum = acc_q[2*WIDTH+1:WIDTH+1];
    endcase
    booth_nxt = {p_sum[WIDTH], p_sum, acc_q[WIDTH:1]};

    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, mcand_q};
    if (trial[WIDTH])
      div_nxt = {1'b0, rem_sh, acc_q[WIDTH-2:0], 1'b0};
    else
      div_nxt = {1'b0, trial, acc_q[WIDTH-2:0], 1'b1};

    quo   = acc_q[WIDTH-1:0];
    rem   = acc_q[2*WIDTH-1:WIDTH];
    abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
  end

  // Next-state, iteration control and result write-back
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b01: begin
              state_d = S_MULT;
              acc_d   = {{(WIDTH+1){1'b0}}, bus.b, 1'b0};
              mcand_d = bus.a;
              cnt_d   = CW'(WIDTH-1);
            end
            2'b10: begin
              if (bus.b == '0) begin
                // divide by zero: report immediately, hi/lo untouched
                done_d = 1'b1;
                dz_d   = 1'b1;
              end else begin
                state_d = S_DIV;
                acc_d   = {{(WIDTH+2){1'b0}}, abs_a};
                mcand_d = abs_b;
                cnt_d   = CW'(WIDTH-1);
                qneg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                rneg_d  = bus.a[WIDTH-1];
              end
            end
            default: ;
          endcase
        end
      end
      S_MULT: begin
        acc_d = booth_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          hi_d    = booth_nxt[2*WIDTH:WIDTH+1];
          lo_d    = booth_nxt[WIDTH:1];
          done_d  = 1'b1;
        end
      end
      S_DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        hi_d    = rneg_q ? -rem : rem;
        lo_d    = qneg_q ? -quo : quo;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers; reset aborts any running operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: vector table plus hand-built handshake/reset
// sequences; results are matched against a FIFO of expected outcomes.
module tb_mult_div_seq;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  mult_div_seq_if #(.WIDTH(W)) bus();
  mult_div_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model built on native 64-bit arithmetic
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sbv, p, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op == 2'b01) begin
      p  = sa * sbv;
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      q  = sa / sbv;
      r  = sa % sbv;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] b);
    if (op == 2'b01) return 33;
    if (b == '0) return 1;
    return 34;
  endfunction

  // Drive a request in the current cycle and queue its expected outcome
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (op == 2'b01 || op == 2'b10) begin
      e.hi = ehi;
      e.lo = elo;
      e.dz = (op == 2'b10) && (b == '0);
      sb.push_back(e);
    end
  endtask

  // Follow cycles N+1..N+lat checking busy/done/div_zero; returns in done cycle
  task automatic track(input int lat, input bit dz, input int inject);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      chk($sformatf("busy@N+%0d", k), W'(bus.busy), W'(k < lat));
      chk($sformatf("done@N+%0d", k), W'(bus.done), W'(k == lat));
      chk($sformatf("div_zero@N+%0d", k), W'(bus.div_zero), W'(dz && (k == lat)));
      if (inject != 0 && k == inject) begin
        bus.start = 1'b1;
        bus.op    = 2'b10;
      end
      if (inject != 0 && k == inject + 1) bus.start = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("idle busy", W'(bus.busy), '0);
      chk("idle done", W'(bus.done), '0);
    end
  endtask

  // Result checker: every done pops the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected done: got done=1, expected no pending op (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("result hi", bus.hi, e.hi);
        chk("result lo", bus.lo, e.lo);
        chk("result div_zero", W'(bus.div_zero), W'(e.dz));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, ehi, elo;
    logic [1:0]   rop;

    tbl[0] = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    tbl[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[6] = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    tbl[7] = '{2'b10, 32'h0000_0009, 32'h0000_0000, 32'h0000_0000, 32'h0000_000F};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    reset     = 1'b1;
    #2;
    chk("reset busy", W'(bus.busy), '0);
    chk("reset done", W'(bus.done), '0);
    chk("reset div_zero", W'(bus.div_zero), '0);
    chk("reset hi", bus.hi, '0);
    chk("reset lo", bus.lo, '0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    // Spec vectors; 6->7 runs back-to-back so the DIV/0 sees the 3*5 result
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
      track(lat_of(tbl[i].op, tbl[i].b), (tbl[i].op == 2'b10) && (tbl[i].b == '0), 0);
      if (i == 2 || i == 4) idle(2);
    end

    // Random operands checked against the native-arithmetic model
    for (int i = 0; i < 8; i++) begin
      rop = (i % 2 == 0) ? 2'b01 : 2'b10;
      ra  = $urandom;
      rb  = $urandom;
      if (i == 3) rb = 32'h0000_0003;
      if (rb == '0) rb = 32'h1;
      model(rop, ra, rb, ehi, elo);
      issue(rop, ra, rb, ehi, elo);
      track(lat_of(rop, rb), 1'b0, 0);
      if (i % 3 == 0) idle(1);
    end

    // Start pulse with DIV during a running MULT must be ignored
    model(2'b01, 32'd123, -32'sd456, ehi, elo);
    issue(2'b01, 32'd123, -32'sd456, ehi, elo);
    track(33, 1'b0, 5);
    idle(1);

    // No-op opcodes
    issue(2'b00, 32'd5, 32'd6, '0, '0);
    idle(4);
    issue(2'b11, 32'd5, 32'd6, '0, '0);
    idle(4);

    // Asynchronous reset in cycle N+10 of a MULT
    issue(2'b01, 32'd11, 32'd13, 32'd0, 32'd143);
    @(posedge clk);
    repeat (9) @(posedge clk);
    bus.start = 1'b0;
    #1;
    chk("pre-reset busy", W'(bus.busy), W'(1));
    #2 reset = 1'b1;
    #1;
    chk("mid-op reset busy", W'(bus.busy), '0);
    chk("mid-op reset done", W'(bus.done), '0);
    chk("mid-op reset hi", bus.hi, '0);
    chk("mid-op reset lo", bus.lo, '0);
    sb.delete();
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
    track(33, 1'b0, 0);
    idle(3);

    chk("scoreboard drained", W'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
